// File: rtl/carregador_instr.sv
// Instruction entry from DE2 switches/buttons: two debounced keys, a 16+16 bit
// word assembler and a valid/ack writer into instruction memory, plus step pulses.
module tecla_debounce #(
    parameter int CICLOS = 50000
) (
    input  logic clock,
    input  logic reset,
    input  logic tecla,
    output logic evento
);
    localparam int CW = $clog2(CICLOS + 1);

    logic [1:0]    sinc;
    logic          nivel;
    logic          nivel_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clock) begin
        if (!reset) begin
            sinc    <= 2'b11;
            nivel   <= 1'b1;
            nivel_d <= 1'b1;
            cnt     <= '0;
            evento  <= 1'b0;
        end else begin
            sinc    <= {sinc[0], tecla};
            nivel_d <= nivel;
            // press = debounced level just went 1->0; releases are silent
            evento  <= nivel_d & ~nivel;
            if (sinc[1] == nivel)
                cnt <= '0;
            else if (cnt == CW'(CICLOS)) begin
                nivel <= ~nivel;
                cnt   <= '0;
            end else
                cnt <= cnt + 1'b1;
        end
    end
endmodule

module carregador_instr #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int ADDR_W          = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              modo_carga,
    input  logic [15:0]       sw_dado,
    input  logic              key_carrega,
    input  logic              key_passo,
    input  logic              mem_ack,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              passo,
    output logic [1:0]        fase
);
    localparam int NUM_TECLAS = 2;

    typedef enum logic [1:0] {
        ESPERA_BAIXO = 2'd0,
        ESPERA_ALTO  = 2'd1,
        ESCRITA      = 2'd2
    } estado_t;

    estado_t                estado, prox;
    logic [NUM_TECLAS-1:0]  teclas;
    logic [NUM_TECLAS-1:0]  eventos;
    logic                   ev_carga;
    logic                   ev_passo;

    assign teclas   = {key_passo, key_carrega};
    assign ev_carga = eventos[0];
    assign ev_passo = eventos[1];

    genvar g;
    generate
        for (g = 0; g < NUM_TECLAS; g++) begin : g_tecla
            tecla_debounce #(.CICLOS(DEBOUNCE_CYCLES)) u_deb (
                .clock  (clock),
                .reset  (reset),
                .tecla  (teclas[g]),
                .evento (eventos[g])
            );
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (!reset) estado <= ESPERA_BAIXO;
        else        estado <= prox;
    end

    always_comb begin
        prox = estado;
        case (estado)
            ESPERA_BAIXO: if (modo_carga && ev_carga) prox = ESPERA_ALTO;
            // leaving load mode abandons a half-entered word
            ESPERA_ALTO: begin
                if (!modo_carga)   prox = ESPERA_BAIXO;
                else if (ev_carga) prox = ESCRITA;
            end
            ESCRITA:     if (mem_ack) prox = ESPERA_BAIXO;
            default:     prox = ESPERA_BAIXO;
        endcase
    end

    always_comb begin
        mem_we = (estado == ESCRITA);
        fase   = estado;
        passo  = ev_passo && !modo_carga && (estado == ESPERA_BAIXO);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (estado)
                ESPERA_BAIXO: if (modo_carga && ev_carga) mem_wdata[15:0]  <= sw_dado;
                ESPERA_ALTO:  if (modo_carga && ev_carga) mem_wdata[31:16] <= sw_dado;
                ESCRITA:      if (mem_ack) mem_addr <= mem_addr + 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_carregador_instr.sv
// Directed bench for carregador_instr: expected writes and step pulses go into
// queues, a negedge monitor pops and compares as the DUT presents them.
module tb_carregador_instr;
    localparam int D = 4;
    localparam int AW = 5;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          modo_carga = 1'b0;
    logic [15:0]   sw_dado = '0;
    logic          key_carrega = 1'b1;
    logic          key_passo = 1'b1;
    logic          mem_ack = 1'b0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          passo;
    logic [1:0]    fase;

    carregador_instr #(.DEBOUNCE_CYCLES(D), .ADDR_W(AW)) dut (
        .clock       (clock),
        .reset       (reset),
        .modo_carga  (modo_carga),
        .sw_dado     (sw_dado),
        .key_carrega (key_carrega),
        .key_passo   (key_passo),
        .mem_ack     (mem_ack),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .passo       (passo),
        .fase        (fase)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t        wr_q[$];
    logic [1:0] passo_q[$];
    int         checks = 0;
    int         passes = 0;
    int         passo_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s got=%h exp=%h", nm, got, exp);
    endtask

    task automatic ciclos(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    // which: 0 = load key, 1 = step key
    task automatic aperta(input bit which);
        if (which) key_passo = 1'b0; else key_carrega = 1'b0;
        ciclos(D + 6);
        if (which) key_passo = 1'b1; else key_carrega = 1'b1;
        ciclos(D + 6);
    endtask

    task automatic carrega(input logic [15:0] lo, input logic [15:0] hi);
        sw_dado = lo;
        aperta(1'b0);
        sw_dado = hi;
        aperta(1'b0);
    endtask

    always @(negedge clock) begin
        if (reset) begin
            if (mem_we && mem_ack) begin
                if (wr_q.size() == 0) begin
                    checks++;
                    $display("FAIL write_unexpected addr=%0d data=%h", mem_addr, mem_wdata);
                end else begin
                    wr_t e;
                    e = wr_q.pop_front();
                    chk("write_addr", 32'(mem_addr), 32'(e.addr));
                    chk("write_data", mem_wdata, e.data);
                end
            end
            if (passo) begin
                passo_cnt++;
                if (passo_q.size() == 0) begin
                    checks++;
                    $display("FAIL passo_unexpected got=1 exp=0");
                end else begin
                    logic [1:0] f;
                    f = passo_q.pop_front();
                    chk("passo_fase", 32'(fase), 32'(f));
                end
            end
        end
    end

    initial begin
        wr_t w;
        // reset state
        ciclos(3);
        @(negedge clock);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_passo", 32'(passo), 32'd0);
        chk("rst_fase", 32'(fase), 32'd0);
        @(posedge clock); #2;
        reset = 1'b1;

        // bounce rejection
        modo_carga = 1'b1;
        for (int i = 0; i < 5; i++) begin
            key_carrega = 1'b0; ciclos(2);
            key_carrega = 1'b1; ciclos(2);
        end
        ciclos(10);
        @(negedge clock);
        chk("bounce_fase", 32'(fase), 32'd0);

        // single load, ack tied high
        mem_ack = 1'b1;
        w.addr = 5'd0; w.data = 32'h20080020; wr_q.push_back(w);
        sw_dado = 16'h0020;
        aperta(1'b0);
        @(negedge clock);
        chk("load_lo_fase", 32'(fase), 32'd1);
        sw_dado = 16'h2008;
        @(posedge clock); #2;
        aperta(1'b0);
        @(negedge clock);
        chk("load_addr_after", 32'(mem_addr), 32'd1);
        chk("load_fase_after", 32'(fase), 32'd0);

        // ack stall
        @(posedge clock); #2;
        mem_ack = 1'b0;
        w.addr = 5'd1; w.data = 32'hABCD1234; wr_q.push_back(w);
        carrega(16'h1234, 16'hABCD);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("stall_we", 32'(mem_we), 32'd1);
            chk("stall_addr", 32'(mem_addr), 32'd1);
            chk("stall_data", mem_wdata, 32'hABCD1234);
        end
        @(posedge clock); #2;
        mem_ack = 1'b1;
        @(posedge clock); #2;
        @(negedge clock);
        chk("stall_we_done", 32'(mem_we), 32'd0);
        chk("stall_addr_done", 32'(mem_addr), 32'd2);

        // wrap: loads 3..32 since reset hit addresses 2..31
        @(posedge clock); #2;
        for (int i = 2; i < 32; i++) begin
            w.addr = AW'(i);
            w.data = {16'(16'hC000 + i), 16'(16'h0100 + i)};
            wr_q.push_back(w);
            carrega(16'(16'h0100 + i), 16'(16'hC000 + i));
        end
        @(negedge clock);
        chk("wrap_addr", 32'(mem_addr), 32'd0);
        chk("wrap_q_empty", 32'(wr_q.size()), 32'd0);

        // abort by leaving load mode after low half
        @(posedge clock); #2;
        sw_dado = 16'h5555;
        aperta(1'b0);
        @(negedge clock);
        chk("abort_fase_lo", 32'(fase), 32'd1);
        @(posedge clock); #2;
        modo_carga = 1'b0;
        @(posedge clock); #2;
        @(negedge clock);
        chk("abort_fase", 32'(fase), 32'd0);
        chk("abort_addr", 32'(mem_addr), 32'd0);
        chk("abort_wdata_lo", 32'(mem_wdata[15:0]), 32'h5555);

        // step in run mode: exactly one pulse
        passo_q.push_back(2'd0);
        @(posedge clock); #2;
        aperta(1'b1);
        @(negedge clock);
        chk("passo_count", passo_cnt, 1);
        // step in load mode: dropped
        @(posedge clock); #2;
        modo_carga = 1'b1;
        aperta(1'b1);
        @(negedge clock);
        chk("passo_gated", passo_cnt, 1);

        // reset mid-write
        @(posedge clock); #2;
        w.addr = 5'd0; w.data = 32'h00FF0077; wr_q.push_back(w);
        carrega(16'h0077, 16'h00FF);
        @(negedge clock);
        chk("pre_rst_addr", 32'(mem_addr), 32'd1);
        @(posedge clock); #2;
        mem_ack = 1'b0;
        carrega(16'h1111, 16'h2222);
        @(negedge clock);
        chk("pre_rst_we", 32'(mem_we), 32'd1);
        @(posedge clock); #2;
        reset = 1'b0;
        @(posedge clock); #2;
        @(negedge clock);
        chk("mid_rst_we", 32'(mem_we), 32'd0);
        chk("mid_rst_addr", 32'(mem_addr), 32'd0);
        chk("mid_rst_fase", 32'(fase), 32'd0);
        chk("mid_rst_passo", 32'(passo), 32'd0);
        @(posedge clock); #2;
        reset = 1'b1;
        ciclos(3);
        chk("end_wr_q_empty", 32'(wr_q.size()), 32'd0);
        chk("end_passo_q_empty", 32'(passo_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
